cvxif_custom_responder: RTL and testbench
=========================================

Name: cvxif_custom_responder

Overview:
- Coprocessor-side responder for the CV-X-IF interface. The core is the initiator; this block implements the coprocessor end.
- Accepts offloaded custom-3 instructions (opcode 7'h7B) from the issue stage and computes results at issue time.
- Holds each result in an in-order pending buffer until the core commits or kills it, then returns committed results over the result channel in issue order.

Parameters:
- XLEN, 32, operand/result width.
- IdWidth, 3, width of the instruction id (covers scoreboard entries).
- Depth, 4, pending-buffer entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request consumed this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_rs_i  in  2*XLEN  {rs2, rs1} operands
- issue_rs_valid_i  in  2  operand valid bits {rs2, rs1}
- issue_accept_o  out  1  instruction is ours (valid with issue_ready_o)
- issue_writeback_o  out  1  accepted instruction will write rd
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  IdWidth  id being committed
- commit_kill_i  in  1  1 = discard, 0 = retire
- result_valid_o  out  1  result available
- result_ready_i  in  1  core accepts result
- result_id_o  out  IdWidth  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable

Behaviour:
- Reset (async, rst_i=1): buffer empty, all entries FREE, head and tail pointers 0. Outputs: issue_ready_o=0, issue_accept_o=0, issue_writeback_o=0, result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0. Reset mid-operation discards all pending entries; no result is emitted afterwards for them.
- Decode (combinational on issue_instr_i): accepted iff opcode==7'h7B and funct7==0 and funct3 in {0,1,2,3}.
  - funct3 0: ADD, rd=rs1+rs2.
  - funct3 1: NOP, accepted, writeback=0.
  - funct3 2: SUB, rd=rs1-rs2.
  - funct3 3: ROR, rd=rs1 rotated right by rs2[4:0].
  - Arithmetic is modulo 2^XLEN.
- Issue handshake:
  - issue_ready_o=1 when issue_valid_i, buffer not full, and the operands the decoded op needs are valid. NOP needs none. An unrecognized instruction needs none and is always ready.
  - Transfer occurs when issue_valid_i & issue_ready_o. issue_accept_o and issue_writeback_o are meaningful only then; otherwise they are 0.
  - A rejected instruction (accept=0) allocates nothing.
  - An accepted instruction allocates the tail entry {id, rd, result, we=writeback} in state WAIT_COMMIT. Result is computed in the same cycle.
  - Full (Depth entries occupied): issue_ready_o=0 for accepted opcodes; rejects are still answered ready=1, accept=0.
- Entry state machine: FREE → WAIT_COMMIT (issue) → READY (commit, kill=0) or KILLED (commit, kill=1) → FREE (head popped).
  - Commit matches every non-FREE entry in WAIT_COMMIT with that id.
  - Commit for an id with no pending entry is ignored.
  - If commit matches the id being issued in the same cycle, it applies to the new entry, which enters READY or KILLED directly.
- Result channel:
  - Registered outputs, driven from the head entry.
  - result_valid_o=1 when head is READY and we=1.
  - Head in KILLED, or READY with we=0 (NOP), is popped silently, one per cycle, without asserting result_valid_o.
  - Pop occurs on result_valid_o & result_ready_i. Outputs hold stable while valid & !ready.
  - Earliest result: the cycle after the commit cycle.
  - Head waiting in WAIT_COMMIT blocks younger READY entries (in-order return).
- Simultaneous pop and issue when full: issue_ready_o stays 0 that cycle (full computed from registered count).
- Pointers wrap modulo Depth. Count range 0..Depth.

Test Plan:
- ADD: rs1=0x0000_0005, rs2=0x0000_0003, id=2, rd=x10; commit id=2 kill=0 next cycle → result_valid_o one cycle after commit, data=0x8, id=2, rd=10, we=1.
- Kill: issue SUB id=1 then ADD id=3, commit id=1 kill=1, commit id=3 kill=0 → only id=3 result appears; no result for id=1.
- Reject: opcode 7'h33 with valid=1 → ready=1, accept=0, writeback=0, buffer count unchanged. NOP funct3=1 → accept=1, writeback=0, and after commit no result_valid_o.
- Full/backpressure: issue 4 ADDs without commit → 5th issue_ready_o=0. Commit all, hold result_ready_i=0 → result held stable. Release → 4 results in issue order; ROR 0x8000_0001 by 1 yields 0xC000_0000.
- Out-of-order commit: issue ids 0,1, commit id 1 first → no output until id 0 committed, then ids 0 then 1 back-to-back.
- Reset asserted with 3 pending entries → all outputs 0 immediately; after release, committing the old ids produces no result.

Source files
------------

// File: rtl/cvxif_custom_responder.sv
// Coprocessor-side CV-X-IF responder for custom-3 (opcode 7'h7B) instructions.
// Results are computed at issue time and held in an in-order pending buffer
// until committed or killed. Committed results return over the result channel
// in issue order.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   issue_*                          issue request / handshake from the core
//   commit_valid_i/id_i/kill_i       commit or kill strobe for one id
//   result_*                         registered result channel (valid/ready)
module cvxif_custom_responder #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IdWidth = 3,
    parameter int unsigned Depth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [31:0]          issue_instr_i,
    input  logic [IdWidth-1:0]   issue_id_i,
    input  logic [2*XLEN-1:0]    issue_rs_i,
    input  logic [1:0]           issue_rs_valid_i,
    output logic                 issue_accept_o,
    output logic                 issue_writeback_o,
    input  logic                 commit_valid_i,
    input  logic [IdWidth-1:0]   commit_id_i,
    input  logic                 commit_kill_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [IdWidth-1:0]   result_id_o,
    output logic [XLEN-1:0]      result_data_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [6:0]  OpCustom3 = 7'h7B;

    typedef enum logic [1:0] {
        FREE        = 2'd0,
        WAIT_COMMIT = 2'd1,
        READY       = 2'd2,
        KILLED      = 2'd3
    } entry_state_e;

    typedef struct packed {
        entry_state_e         state;
        logic [IdWidth-1:0]   id;
        logic [4:0]           rd;
        logic [XLEN-1:0]      data;
        logic                 we;
    } entry_t;

    entry_t          ent_q [Depth];
    entry_t          ent_n [Depth];
    entry_t          hd_n;
    logic [PtrW-1:0] head_q, head_n, tail_q, tail_n;
    logic [CntW-1:0] count_q, count_n;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1, rs2, alu_res;
    logic            is_ours, is_nop, ops_ok, full, ours_fire, pop, res_valid_n;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^issue_instr_i[24:15];

    // Decode, operand availability and issue handshake.
    always_comb begin
        opcode  = issue_instr_i[6:0];
        funct3  = issue_instr_i[14:12];
        funct7  = issue_instr_i[31:25];
        rs1     = issue_rs_i[XLEN-1:0];
        rs2     = issue_rs_i[2*XLEN-1:XLEN];
        is_ours = (opcode == OpCustom3) && (funct7 == 7'd0) && !funct3[2];
        is_nop  = (funct3 == 3'd1);
        ops_ok  = is_nop || (&issue_rs_valid_i);
        full    = (count_q == CntW'(Depth));
        // Rejects never need a slot, so they are answered even when full.
        issue_ready_o     = !rst_i && issue_valid_i && (!is_ours || (!full && ops_ok));
        ours_fire         = issue_ready_o && is_ours;
        issue_accept_o    = ours_fire;
        issue_writeback_o = ours_fire && !is_nop;
        unique case (funct3[1:0])
            2'd0:    alu_res = rs1 + rs2;
            2'd1:    alu_res = '0;
            2'd2:    alu_res = rs1 - rs2;
            default: alu_res = XLEN'({rs1, rs1} >> rs2[4:0]);
        endcase
    end

    // Next-state of the pending buffer: commit, head pop, tail allocation.
    always_comb begin
        ent_n   = ent_q;
        head_n  = head_q;
        tail_n  = tail_q;
        pop     = 1'b0;

        if (commit_valid_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (ent_q[i].state == WAIT_COMMIT && ent_q[i].id == commit_id_i) begin
                    ent_n[i].state = commit_kill_i ? KILLED : READY;
                end
            end
        end

        // Killed entries and NOP results drain silently, one per cycle.
        unique case (ent_q[head_q].state)
            KILLED:  pop = 1'b1;
            READY:   pop = !ent_q[head_q].we || (result_valid_o && result_ready_i);
            default: pop = 1'b0;
        endcase
        if (pop) begin
            ent_n[head_q].state = FREE;
            head_n              = head_q + PtrW'(1);
        end

        // A commit for the id being issued lands on the new entry directly.
        if (ours_fire) begin
            ent_n[tail_q].id   = issue_id_i;
            ent_n[tail_q].rd   = issue_instr_i[11:7];
            ent_n[tail_q].data = alu_res;
            ent_n[tail_q].we   = !is_nop;
            if (commit_valid_i && commit_id_i == issue_id_i) begin
                ent_n[tail_q].state = commit_kill_i ? KILLED : READY;
            end else begin
                ent_n[tail_q].state = WAIT_COMMIT;
            end
            tail_n = tail_q + PtrW'(1);
        end

        count_n = count_q + CntW'(ours_fire) - CntW'(pop);
    end

    // Result registers look at the post-update head so a result appears the
    // cycle right after its commit.
    assign hd_n        = ent_n[head_n];
    assign res_valid_n = (hd_n.state == READY) && hd_n.we;

    // State and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                ent_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_data_o  <= '0;
            result_rd_o    <= '0;
            result_we_o    <= 1'b0;
        end else begin
            ent_q          <= ent_n;
            head_q         <= head_n;
            tail_q         <= tail_n;
            count_q        <= count_n;
            result_valid_o <= res_valid_n;
            result_id_o    <= res_valid_n ? hd_n.id   : '0;
            result_data_o  <= res_valid_n ? hd_n.data : '0;
            result_rd_o    <= res_valid_n ? hd_n.rd   : '0;
            result_we_o    <= res_valid_n;
        end
    end

endmodule

// File: tb/tb_cvxif_custom_responder.sv
// Directed bench for cvxif_custom_responder: inputs change on the falling
// edge, registered outputs are checked on the falling edge, handshake
// outputs 1 ns after inputs settle.
module tb_cvxif_custom_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [2:0]  issue_id_i;
    logic [63:0] issue_rs_i;
    logic [1:0]  issue_rs_valid_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [2:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [2:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    logic [2:0]  iss_obs;
    logic [41:0] res_obs;
    int          vectors = 0;
    int          miscompares = 0;

    assign iss_obs = {issue_ready_o, issue_accept_o, issue_writeback_o};
    assign res_obs = {result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o};

    always #5 clk_i = ~clk_i;

    cvxif_custom_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o)
    );

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd0, 5'd0, f3, rd, op};
    endfunction

    task automatic set_issue(input logic [31:0] instr, input logic [2:0] id,
                             input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv);
        issue_valid_i    = 1'b1;
        issue_instr_i    = instr;
        issue_id_i       = id;
        issue_rs_i       = {b, a};
        issue_rs_valid_i = rsv;
    endtask

    task automatic no_issue();
        issue_valid_i    = 1'b0;
        issue_instr_i    = '0;
        issue_id_i       = '0;
        issue_rs_i       = '0;
        issue_rs_valid_i = '0;
    endtask

    task automatic set_commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic no_commit();
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        result_ready_i = 1'b1;
        no_commit();
        set_issue(enc(7'd0, 3'd0, 5'd1, 7'h7B), 3'd0, 32'd1, 32'd1, 2'b11);
        repeat (2) @(negedge clk_i);
        vectors++;
        if (iss_obs !== 3'b000) begin
            miscompares++; $display("FAIL reset_issue: got %b want 000", iss_obs);
        end
        vectors++;
        if (res_obs !== 42'd0) begin
            miscompares++; $display("FAIL reset_result: got %h want 0", res_obs);
        end
        no_issue();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_add();
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd0, 5'd10, 7'h7B), 3'd2, 32'd5, 32'd3, 2'b11);
        #1;
        vectors++;
        if (iss_obs !== 3'b111) begin
            miscompares++; $display("FAIL add_issue: got %b want 111", iss_obs);
        end
        @(negedge clk_i);
        no_issue(); set_commit(3'd2, 1'b0);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL add_early: got valid %b want 0", result_valid_o);
        end
        @(negedge clk_i);
        no_commit();
        vectors++;
        if (res_obs !== {1'b1, 3'd2, 5'd10, 32'd8, 1'b1}) begin
            miscompares++; $display("FAIL add_result: got %h want %h", res_obs, {1'b1, 3'd2, 5'd10, 32'd8, 1'b1});
        end
        @(negedge clk_i);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL add_drain: got valid %b want 0", result_valid_o);
        end
    endtask

    task automatic test_kill();
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd2, 5'd5, 7'h7B), 3'd1, 32'd10, 32'd3, 2'b11);
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd0, 5'd6, 7'h7B), 3'd3, 32'd1, 32'd2, 2'b11);
        @(negedge clk_i);
        no_issue(); set_commit(3'd1, 1'b1);
        @(negedge clk_i);
        set_commit(3'd3, 1'b0);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL kill_suppressed: got valid %b want 0", result_valid_o);
        end
        @(negedge clk_i);
        no_commit();
        vectors++;
        if (res_obs !== {1'b1, 3'd3, 5'd6, 32'd3, 1'b1}) begin
            miscompares++; $display("FAIL kill_survivor: got %h want %h", res_obs, {1'b1, 3'd3, 5'd6, 32'd3, 1'b1});
        end
        @(negedge clk_i);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL kill_drain: got valid %b want 0", result_valid_o);
        end
    endtask

    task automatic test_reject();
        logic [31:0] instr [5];
        logic [1:0]  rsv [5];
        logic [2:0]  exp [5];
        instr[0] = enc(7'd0, 3'd0, 5'd1, 7'h33); rsv[0] = 2'b00; exp[0] = 3'b100;
        instr[1] = enc(7'd1, 3'd0, 5'd1, 7'h7B); rsv[1] = 2'b00; exp[1] = 3'b100;
        instr[2] = enc(7'd0, 3'd4, 5'd1, 7'h7B); rsv[2] = 2'b00; exp[2] = 3'b100;
        instr[3] = enc(7'd0, 3'd0, 5'd1, 7'h7B); rsv[3] = 2'b01; exp[3] = 3'b000;
        instr[4] = enc(7'd0, 3'd3, 5'd1, 7'h7B); rsv[4] = 2'b10; exp[4] = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            set_issue(instr[k], 3'd0, 32'd7, 32'd7, rsv[k]);
            #1;
            vectors++;
            if (iss_obs !== exp[k]) begin
                miscompares++; $display("FAIL reject_%0d: got %b want %b", k, iss_obs, exp[k]);
            end
        end
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd1, 5'd2, 7'h7B), 3'd4, 32'd0, 32'd0, 2'b00);
        #1;
        vectors++;
        if (iss_obs !== 3'b110) begin
            miscompares++; $display("FAIL nop_issue: got %b want 110", iss_obs);
        end
        @(negedge clk_i);
        no_issue(); set_commit(3'd4, 1'b0);
        @(negedge clk_i);
        no_commit();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (result_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL nop_silent_%0d: got valid %b want 0", k, result_valid_o);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_full();
        logic [2:0]  f3 [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] exp [4];
        logic [41:0] want;
        f3[0] = 3'd0; a[0] = 32'd1;          b[0] = 32'd1; exp[0] = 32'd2;
        f3[1] = 3'd2; a[1] = 32'd10;         b[1] = 32'd3; exp[1] = 32'd7;
        f3[2] = 3'd3; a[2] = 32'h8000_0001; b[2] = 32'd1; exp[2] = 32'hC000_0000;
        f3[3] = 3'd0; a[3] = 32'hFFFF_FFFF; b[3] = 32'd2; exp[3] = 32'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            set_issue(enc(7'd0, f3[k], 5'(k + 1), 7'h7B), 3'(k), a[k], b[k], 2'b11);
            #1;
            vectors++;
            if (iss_obs !== 3'b111) begin
                miscompares++; $display("FAIL full_fill_%0d: got %b want 111", k, iss_obs);
            end
        end
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd0, 5'd9, 7'h7B), 3'd4, 32'd1, 32'd1, 2'b11);
        #1;
        vectors++;
        if (iss_obs !== 3'b000) begin
            miscompares++; $display("FAIL full_block: got %b want 000", iss_obs);
        end
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd0, 5'd9, 7'h33), 3'd4, 32'd1, 32'd1, 2'b11);
        #1;
        vectors++;
        if (iss_obs !== 3'b100) begin
            miscompares++; $display("FAIL full_reject: got %b want 100", iss_obs);
        end
        @(negedge clk_i);
        no_issue(); result_ready_i = 1'b0; set_commit(3'd0, 1'b0);
        want = {1'b1, 3'd0, 5'd1, exp[0], 1'b1};
        for (int k = 1; k < 6; k++) begin
            @(negedge clk_i);
            if (k < 4) set_commit(3'(k), 1'b0);
            else no_commit();
            vectors++;
            if (res_obs !== want) begin
                miscompares++; $display("FAIL full_hold_%0d: got %h want %h", k, res_obs, want);
            end
        end
        result_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            want = {1'b1, 3'(k), 5'(k + 1), exp[k], 1'b1};
            vectors++;
            if (res_obs !== want) begin
                miscompares++; $display("FAIL full_order_%0d: got %h want %h", k, res_obs, want);
            end
        end
        @(negedge clk_i);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL full_drain: got valid %b want 0", result_valid_o);
        end
    endtask

    task automatic test_out_of_order();
        @(negedge clk_i);
        set_commit(3'd7, 1'b0);
        @(negedge clk_i);
        no_commit();
        set_issue(enc(7'd0, 3'd0, 5'd3, 7'h7B), 3'd0, 32'd2, 32'd2, 2'b11);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL ooo_stray_commit: got valid %b want 0", result_valid_o);
        end
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd0, 5'd4, 7'h7B), 3'd1, 32'd3, 32'd3, 2'b11);
        @(negedge clk_i);
        no_issue(); set_commit(3'd1, 1'b0);
        @(negedge clk_i);
        no_commit();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (result_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL ooo_blocked_%0d: got valid %b want 0", k, result_valid_o);
            end
            @(negedge clk_i);
        end
        set_commit(3'd0, 1'b0);
        @(negedge clk_i);
        no_commit();
        vectors++;
        if (res_obs !== {1'b1, 3'd0, 5'd3, 32'd4, 1'b1}) begin
            miscompares++; $display("FAIL ooo_first: got %h want %h", res_obs, {1'b1, 3'd0, 5'd3, 32'd4, 1'b1});
        end
        @(negedge clk_i);
        vectors++;
        if (res_obs !== {1'b1, 3'd1, 5'd4, 32'd6, 1'b1}) begin
            miscompares++; $display("FAIL ooo_second: got %h want %h", res_obs, {1'b1, 3'd1, 5'd4, 32'd6, 1'b1});
        end
        @(negedge clk_i);
        vectors++;
        if (result_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL ooo_drain: got valid %b want 0", result_valid_o);
        end
    endtask

    task automatic test_same_cycle_commit();
        @(negedge clk_i);
        set_issue(enc(7'd0, 3'd0, 5'd7, 7'h7B), 3'd5, 32'd100, 32'd23, 2'b11);
        set_commit(3'd5, 1'b0);
        @(negedge clk_i);
        no_issue(); no_commit();
        vectors++;
        if (res_obs !== {1'b1, 3'd5, 5'd7, 32'd123, 1'b1}) begin
            miscompares++; $display("FAIL same_cycle_retire: got %h want %h", res_obs, {1'b1, 3'd5, 5'd7, 32'd123, 1'b1});
        end
        set_issue(enc(7'd0, 3'd0, 5'd8, 7'h7B), 3'd6, 32'd1, 32'd1, 2'b11);
        set_commit(3'd6, 1'b1);
        @(negedge clk_i);
        no_issue(); no_commit();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            vectors++;
            if (result_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL same_cycle_kill_%0d: got valid %b want 0", k, result_valid_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        result_ready_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            set_issue(enc(7'd0, 3'd0, 5'(k), 7'h7B), 3'(k), 32'd1, 32'd1, 2'b11);
        end
        @(negedge clk_i);
        no_issue(); set_commit(3'd1, 1'b0);
        @(negedge clk_i);
        no_commit();
        vectors++;
        if (res_obs !== {1'b1, 3'd1, 5'd1, 32'd2, 1'b1}) begin
            miscompares++; $display("FAIL rstmid_pending: got %h want %h", res_obs, {1'b1, 3'd1, 5'd1, 32'd2, 1'b1});
        end
        rst_i = 1'b1;
        #1;
        vectors++;
        if (res_obs !== 42'd0) begin
            miscompares++; $display("FAIL rstmid_clear: got %h want 0", res_obs);
        end
        @(negedge clk_i);
        rst_i = 1'b0; result_ready_i = 1'b1;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk_i);
            if (k < 4) set_commit(3'(k), 1'b0);
            else no_commit();
            vectors++;
            if (result_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL rstmid_stale_%0d: got valid %b want 0", k, result_valid_o);
            end
        end
        set_issue(enc(7'd0, 3'd0, 5'd9, 7'h7B), 3'd2, 32'd7, 32'd8, 2'b11);
        set_commit(3'd2, 1'b0);
        @(negedge clk_i);
        no_issue(); no_commit();
        vectors++;
        if (res_obs !== {1'b1, 3'd2, 5'd9, 32'd15, 1'b1}) begin
            miscompares++; $display("FAIL rstmid_fresh: got %h want %h", res_obs, {1'b1, 3'd2, 5'd9, 32'd15, 1'b1});
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_add();
        test_kill();
        test_reject();
        test_full();
        test_out_of_order();
        test_same_cycle_commit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
